// File: rtl/muldiv_unit.sv
// Iterative MUL/MUH/DIV/MOD unit (signed/unsigned) with a one-entry paired-half result cache.
// Optional feature macro: MULDIV_DIV_EN (divider datapath, DIV state, div-class cache entries).
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 2
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic             is_unsign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int CW      = $clog2(WIDTH);
  localparam int MUL_CYC = WIDTH / MUL_STEP;

  // Handshake: execute holds enable high until done; a request is accepted only in
  // IDLE with flush low, and done is a single-cycle pulse with result valid alongside it.

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]         op_q;
  logic               uns_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic               c_valid, c_uns, c_cls;
  logic [WIDTH-1:0]   c_a, c_b;
  logic [2*WIDTH-1:0] c_data;

  logic                      accept, hit, a_neg, b_neg;
  logic [WIDTH-1:0]          a_mag, b_mag, hit_half, step_m;
  logic [2*WIDTH-1:0]        step_acc, mul_next;
  logic [MUL_STEP-1:0]       digit;
  logic [WIDTH+MUL_STEP-1:0] pprod, psum;
  logic                      sgn_a, sgn_b;
  logic [2*WIDTH-1:0]        fix_data;
  logic [WIDTH-1:0]          fix_half;

  assign accept   = (state == S_IDLE) && enable && !flush;
  assign hit      = c_valid && (c_a == a) && (c_b == b) && (c_uns == is_unsign) && (c_cls == op[1]);
  assign hit_half = op[0] ? c_data[2*WIDTH-1:WIDTH] : c_data[WIDTH-1:0];

  assign a_neg = !is_unsign && a[WIDTH-1];
  assign b_neg = !is_unsign && b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // The accepting edge already performs the first iteration, straight from the ports.
  always_comb begin
    step_acc = acc;
    step_m   = mcand;
    if (state == S_IDLE) begin
      step_acc = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      step_m   = op[1] ? b_mag : a_mag;
    end
  end

  // Multiplier sits in the low half of acc and shifts out as the product shifts in.
  assign digit    = step_acc[MUL_STEP-1:0];
  assign pprod    = {{MUL_STEP{1'b0}}, step_m} * {{WIDTH{1'b0}}, digit};
  assign psum     = {{MUL_STEP{1'b0}}, step_acc[2*WIDTH-1:WIDTH]} + pprod;
  assign mul_next = {psum, step_acc[WIDTH-1:MUL_STEP]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     rem_shift, diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   rem_fix, quo_fix;

  // acc = {remainder, dividend/quotient}; diff[WIDTH] is the borrow of the trial subtract.
  assign rem_shift = {step_acc[2*WIDTH-1:WIDTH], step_acc[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, step_m};
  assign div_next  = diff[WIDTH] ? {rem_shift[WIDTH-1:0], step_acc[WIDTH-2:0], 1'b0}
                                 : {diff[WIDTH-1:0], step_acc[WIDTH-2:0], 1'b1};
  assign rem_fix   = sgn_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign quo_fix   = (sgn_a ^ sgn_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
`endif

  assign sgn_a = !uns_q && a_q[WIDTH-1];
  assign sgn_b = !uns_q && b_q[WIDTH-1];

  always_comb begin
    fix_data = (sgn_a ^ sgn_b) ? -acc : acc;
`ifdef MULDIV_DIV_EN
    if (op_q[1]) fix_data = {rem_fix, quo_fix};
`endif
  end

  assign fix_half = op_q[0] ? fix_data[2*WIDTH-1:WIDTH] : fix_data[WIDTH-1:0];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (hit) begin
            state_nx = S_DONE;
          end else if (op[1]) begin
`ifdef MULDIV_DIV_EN
            state_nx = (b == '0) ? S_DONE : S_DIV;
`else
            state_nx = S_DONE;
`endif
          end else begin
            state_nx = S_MUL;
          end
        end
      end
      S_MUL, S_DIV: if (cnt == '0) state_nx = S_FIX;
      S_FIX:        state_nx = S_DONE;
      S_DONE:       state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      result  <= '0;
      op_q    <= '0;
      uns_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      c_valid <= 1'b0;
      c_uns   <= 1'b0;
      c_cls   <= 1'b0;
      c_a     <= '0;
      c_b     <= '0;
      c_data  <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        c_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (enable) begin
              op_q  <= op;
              uns_q <= is_unsign;
              a_q   <= a;
              b_q   <= b;
              if (hit) begin
                result <= hit_half;
              end else if (op[1]) begin
`ifdef MULDIV_DIV_EN
                if (b == '0) begin
                  result <= op[0] ? a : '1;
                end else begin
                  acc   <= div_next;
                  mcand <= b_mag;
                  cnt   <= CW'(WIDTH - 2);
                end
`else
                result <= '0;
`endif
              end else begin
                acc   <= mul_next;
                mcand <= a_mag;
                cnt   <= CW'(MUL_CYC - 2);
              end
            end
          end
          S_MUL: begin
            acc <= mul_next;
            cnt <= cnt - CW'(1);
          end
`ifdef MULDIV_DIV_EN
          S_DIV: begin
            acc <= div_next;
            cnt <= cnt - CW'(1);
          end
`endif
          S_FIX: begin
            result  <= fix_half;
            c_valid <= 1'b1;
            c_a     <= a_q;
            c_b     <= b_q;
            c_uns   <= uns_q;
            c_cls   <= op_q[1];
            c_data  <= fix_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, random ops against a reference model,
// flush and mid-operation reset sequences; follows MULDIV_DIV_EN like the design.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         sys_clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         flush;
  logic [1:0]   op_i;
  logic         uns_i;
  logic [W-1:0] a_i, b_i;
  logic [W-1:0] result;
  logic         done, busy;

  muldiv_unit #(.WIDTH(W), .MUL_STEP(2)) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .flush     (flush),
    .op        (op_i),
    .is_unsign (uns_i),
    .a         (a_i),
    .b         (b_i),
    .result    (result),
    .done      (done),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  // Reference cache model used only to predict latency.
  logic         m_valid = 1'b0;
  logic         m_uns, m_cls;
  logic [W-1:0] m_a, m_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic u,
                                          input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
`ifdef MULDIV_DIV_EN
    logic signed [W-1:0] sx, sy;
    sx = x;
    sy = y;
`endif
    if (!o[1]) begin
      if (u) p = {32'b0, x} * {32'b0, y};
      else   p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      return o[0] ? p[63:32] : p[31:0];
    end
`ifdef MULDIV_DIV_EN
    if (y == 0) return o[0] ? x : 32'hFFFF_FFFF;
    if (u) return o[0] ? x % y : x / y;
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[0] ? 32'h0 : 32'h8000_0000;
    return o[0] ? 32'(sx % sy) : 32'(sx / sy);
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_lat(input logic [1:0] o, input logic u, input logic [W-1:0] x,
                           input logic [W-1:0] y, output int l);
    if (m_valid && m_a == x && m_b == y && m_uns == u && m_cls == o[1]) begin
      l = 1;
    end else if (o[1]) begin
`ifdef MULDIV_DIV_EN
      if (y == 0) begin
        l = 1;
      end else begin
        l = W + 1;
        m_valid = 1'b1; m_a = x; m_b = y; m_uns = u; m_cls = 1'b1;
      end
`else
      l = 1;
`endif
    end else begin
      l = W / 2 + 1;
      m_valid = 1'b1; m_a = x; m_b = y; m_uns = u; m_cls = 1'b0;
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge with the unit idle again.
  task automatic run_op(input logic [1:0] o, input logic u, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] exp_res, input string name);
    int lat, el;
    model_lat(o, u, x, y, el);
    exp_q.push_back(exp_res);
    lat_q.push_back(el);
    op_i = o; uns_i = u; a_i = x; b_i = y; enable = 1'b1;
    @(posedge sys_clk);
    lat = 1;
    @(negedge sys_clk);
    a_i = $urandom;
    b_i = $urandom;
    op_i = 2'($urandom_range(0, 3));
    while (!done && lat < 200) begin
      @(posedge sys_clk);
      lat++;
      @(negedge sys_clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within %0d edges", name, lat);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
    end else begin
      check({name, " result"}, 64'(result), 64'(exp_q.pop_front()));
      check({name, " latency"}, 64'(lat), 64'(lat_q.pop_front()));
    end
    @(posedge sys_clk);
    @(negedge sys_clk);
    check({name, " done pulse width"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic         uns;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  initial begin
    logic [W-1:0] exp_v, ra, rb;
    logic [1:0]   ro;
    logic         ru;
    int           cyc, seen;

    tbl[0]  = '{2'b00, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[1]  = '{2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    tbl[2]  = '{2'b01, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF};
    tbl[3]  = '{2'b00, 1'b0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1};
    tbl[4]  = '{2'b00, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFF1};
    tbl[5]  = '{2'b10, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    tbl[6]  = '{2'b11, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    tbl[7]  = '{2'b10, 1'b1, 32'd100,       32'd7,         32'd14};
    tbl[8]  = '{2'b11, 1'b1, 32'd100,       32'd7,         32'd2};
    tbl[9]  = '{2'b10, 1'b1, 32'h0000_1234, 32'h0,         32'hFFFF_FFFF};
    tbl[10] = '{2'b11, 1'b1, 32'h0000_1234, 32'h0,         32'h0000_1234};
    tbl[11] = '{2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    tbl[12] = '{2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    tbl[13] = '{2'b00, 1'b0, 32'd6,         32'd7,         32'd42};
    tbl[14] = '{2'b00, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0};
    tbl[15] = '{2'b01, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[16] = '{2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    tbl[17] = '{2'b11, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1};
    tbl[18] = '{2'b10, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    tbl[19] = '{2'b01, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};

    // Clock/reset
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0;
    op_i = 2'b00; uns_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset result", 64'(result), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge sys_clk);

    // Directed table, issued back to back
    for (int i = 0; i < NV; i++) begin
      exp_v = tbl[i].res;
`ifndef MULDIV_DIV_EN
      if (tbl[i].op[1]) exp_v = '0;
`endif
      run_op(tbl[i].op, tbl[i].uns, tbl[i].a, tbl[i].b, exp_v, $sformatf("vec%0d", i));
    end

    // Random ops against the reference model, often reusing operands to hit the cache
    ra = $urandom; rb = $urandom; ru = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) != 0) begin
        ra = $urandom;
        rb = ($urandom_range(0, 5) == 0) ? 32'h0 : 32'($urandom_range(0, 3) == 0 ? $urandom_range(1, 300) : $urandom);
        ru = 1'($urandom_range(0, 1));
      end
      run_op(ro, ru, ra, rb, ref_op(ro, ru, ra, rb), $sformatf("rnd%0d", i));
    end

    // Flush mid-MUL: busy drops next edge, no done, cache invalidated
    run_op(2'b01, 1'b1, 32'h0001_1111, 32'h0002_2222, ref_op(2'b01, 1'b1, 32'h0001_1111, 32'h0002_2222), "flush_pre");
    op_i = 2'b00; uns_i = 1'b1; a_i = 32'h33; b_i = 32'h44; enable = 1'b1;
    m_valid = 1'b0;
    seen = 0;
    @(posedge sys_clk);
    for (cyc = 0; cyc < 5; cyc++) begin
      @(negedge sys_clk);
      if (done) seen++;
      @(posedge sys_clk);
    end
    @(negedge sys_clk);
    check("flush busy before", 64'(busy), 64'd1);
    flush = 1'b1; enable = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    flush = 1'b0;
    check("flush busy after", 64'(busy), 64'd0);
    check("flush no done", 64'(done), 64'd0);
    repeat (20) begin
      @(negedge sys_clk);
      if (done) seen++;
    end
    check("flush done pulses", 64'(seen), 64'd0);
    run_op(2'b00, 1'b1, 32'h0001_1111, 32'h0002_2222, ref_op(2'b00, 1'b1, 32'h0001_1111, 32'h0002_2222), "flush_reissue");

    // Reset mid-operation: outputs back to reset values, cache invalidated
`ifdef MULDIV_DIV_EN
    op_i = 2'b10;
`else
    op_i = 2'b00;
`endif
    uns_i = 1'b1; a_i = 32'd1000; b_i = 32'd3; enable = 1'b1;
    @(posedge sys_clk);
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0; enable = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("mid reset result", 64'(result), 64'd0);
    check("mid reset done", 64'(done), 64'd0);
    check("mid reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    m_valid = 1'b0;
    @(negedge sys_clk);
    run_op(2'b00, 1'b1, 32'h0001_1111, 32'h0002_2222, ref_op(2'b00, 1'b1, 32'h0001_1111, 32'h0002_2222), "reset_reissue");

    enable = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("idle busy", 64'(busy), 64'd0);
    check("scoreboard empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
